pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register, the successor to the fixed-field inter-stage latches between IF/ID/EX/MEM/WB. It carries an arbitrary WIDTH-bit packed payload (instruction, PC, operands, control bundle) with a valid/ready handshake. A 2-entry skid buffer gives full throughput while breaking the combinational ready path. It also provides global enable (stall), synchronous flush (bubble insert) and optional performance counters.

Parameters:
WIDTH, 32, payload width in bits (>=1)
RESET_VAL, {WIDTH{1'b0}}, value loaded into both payload registers on in_CLR or in_flush
CNT_W, 16, width of the optional performance counters

Ports:
in_CLK  input  1  clock, rising edge
in_CLR  input  1  reset, asynchronous, active-high
in_EN  input  1  global stage enable; 0 freezes all handshake state
in_flush  input  1  synchronous flush; discards all held and incoming entries
in_valid  input  1  upstream payload valid
in_data  input  WIDTH  upstream payload
in_ready  input  1  downstream ready to accept
out_ready  output  1  ready to upstream
out_valid  output  1  payload valid to downstream
out_data  output  WIDTH  payload to downstream
out_stall_cnt  output  CNT_W  stall-cycle counter (optional feature)
out_bubble_cnt  output  CNT_W  bubble-cycle counter (optional feature)

Behaviour:
- Internal state: main_v/main_d (drives out_valid/out_data) and skid_v/skid_d.
- Reset: in_CLR=1 asynchronously sets main_v=0, skid_v=0, main_d=skid_d=RESET_VAL and counters=0. Outputs are out_valid=0 and out_data=RESET_VAL. out_ready = in_EN & ~skid_v, so it is 1 once in_EN=1.
- Handshake terms: acc = in_EN & in_valid & out_ready; pop = in_EN & main_v & in_ready.
- out_ready depends only on registered skid_v and on in_EN, never on in_ready.
- State EMPTY (main_v=0, skid_v=0):
  - acc -> ONE, main_d<=in_data.
- State ONE (main_v=1, skid_v=0):
  - acc&pop -> ONE, main_d<=in_data.
  - acc&~pop -> FULL, skid_d<=in_data.
  - pop&~acc -> EMPTY.
  - neither -> hold.
- State FULL (both valid): out_ready=0, so acc is impossible.
  - pop -> ONE, main_d<=skid_d.
  - no pop -> hold.
- Latency: in_data accepted at edge N appears on out_data with out_valid=1 after edge N. Minimum latency is 1 cycle.
- Throughput: 1 transfer/cycle sustained when in_ready=1.
- Ordering: strict FIFO order; no drop, no duplication.
- out_data is only meaningful when out_valid=1. When main_v falls to 0 through a pop, main_d retains its last value.
- in_EN=0: no acc, no pop, all state held, out_ready=0. out_valid and out_data stay visible, but the downstream must not treat them as consumed.
- in_flush=1 at an edge: main_v=0, skid_v=0, both data regs<=RESET_VAL. This holds regardless of in_EN. A coincident acc or pop is discarded/ignored. Flush has priority below in_CLR only.
- in_CLR asserted mid-transfer: all entries are lost immediately, with no partial update.

Optional Feature:
Macro STAGE_PERF_CNT_EN.
- Defined:
  - out_stall_cnt increments on each edge with in_EN & main_v & ~in_ready.
  - out_bubble_cnt increments on each edge with in_EN & ~main_v.
  - Both counters saturate at all-ones (no wrap) and are cleared only by in_CLR; in_flush does not clear them.
- Not defined: both ports remain present and are tied to 0. No counter flops are inferred.

Test Plan:
- Reset then stream: CLR pulse; in_EN=1, in_ready=1; push 0x11,0x22,0x33 on consecutive cycles -> out_valid=1 from the cycle after the first push; out_data=0x11,0x22,0x33 on consecutive cycles; out_ready stays 1.
- Backpressure/skid: push 0xA1,0xA2 with in_ready=0 -> FULL, out_ready=0, out_data=0xA1. Raise in_ready -> 0xA1 popped then 0xA2; out_ready returns to 1 one cycle after the first pop; no loss.
- Stall: in FULL state, drop in_EN for 3 cycles with in_valid=1 and in_ready=1 -> no state change, out_ready=0, out_data held at 0xA1; order intact after in_EN returns.
- Flush: in FULL state, assert in_flush together with in_valid=1 (0xFF) -> next cycle out_valid=0, out_data=RESET_VAL, out_ready=1; 0xFF is never output.
- Async reset: assert in_CLR between clock edges in ONE state -> out_valid=0 and out_data=RESET_VAL immediately, without waiting for a clock edge.
- Counters (STAGE_PERF_CNT_EN, CNT_W=4): hold out_valid=1 with in_ready=0 for 20 cycles -> out_stall_cnt=15 (saturated). Flush -> counter stays 15. CLR -> 0.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_skid_if : valid/ready payload bundle around one pipe stage     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface pipe_stage_skid_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  // slave: the stage itself; master: the surrounding pipeline
  modport slave (
    input  in_valid, in_data, in_ready,
    output out_ready, out_valid, out_data
  );
  modport master (
    output in_valid, in_data, in_ready,
    input  out_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_skid : 2-entry skid pipeline register with stall/flush/perf   |
// | Optional counters enabled by macro STAGE_PERF_CNT_EN                     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             in_CLK,
  input  logic             in_CLR,
  input  logic             in_EN,
  input  logic             in_flush,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] out_stall_cnt,
  output logic [CNT_W-1:0] out_bubble_cnt
);

  // state[0] is main_v, state[1] is skid_v
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  logic [1:0]       state;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic             main_v;
  logic             skid_v;
  logic             ready;
  logic             acc;
  logic             pop;

  assign main_v = state[0];
  assign skid_v = state[1];

  // ready comes only from registered state, never from downstream ready
  assign ready = in_EN & ~skid_v;
  assign acc   = in_EN & bus.in_valid & ready;
  assign pop   = in_EN & main_v & bus.in_ready;

  assign bus.out_ready = ready;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_d;

  always_ff @(posedge in_CLK or posedge in_CLR) begin
    if (in_CLR) begin
      state  <= EMPTY;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
    end else if (in_flush) begin
      state  <= EMPTY;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state  <= ONE;
            main_d <= bus.in_data;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_d <= bus.in_data;
          end else if (acc) begin
            state  <= FULL;
            skid_d <= bus.in_data;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state  <= ONE;
            main_d <= skid_d;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  // saturating counters; flush deliberately leaves them alone
  always_ff @(posedge in_CLK or posedge in_CLR) begin
    if (in_CLR) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (in_EN && main_v && !bus.in_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (in_EN && !main_v && !(&bubble_cnt))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign out_stall_cnt  = stall_cnt;
  assign out_bubble_cnt = bubble_cnt;
`else
  assign out_stall_cnt  = '0;
  assign out_bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_skid : directed stimulus with queue scoreboard             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 4;
  localparam logic [7:0] RVAL  = 8'h5A;

  logic             clk = 1'b0;
  logic             clr;
  logic             en;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];

  pipe_stage_skid_if #(.WIDTH(WIDTH)) bus ();

  pipe_stage_skid #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RVAL),
    .CNT_W     (CNT_W)
  ) dut (
    .in_CLK         (clk),
    .in_CLR         (clr),
    .in_EN          (en),
    .in_flush       (flush),
    .bus            (bus),
    .out_stall_cnt  (stall_cnt),
    .out_bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive at a falling edge, push expected payload if it will be accepted,
  // then wait one full cycle so outputs reflect the rising edge in between
  task automatic drive(input logic v, input logic [7:0] d, input logic r,
                       input logic e, input logic f, input logic push);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ready = r;
    en           = e;
    flush        = f;
    if (push) sb.push_back(d);
    @(negedge clk);
  endtask

  // monitor: just before each rising edge, a transfer downstream is due
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      #4;
      if (!clr && en && !flush && bus.out_valid && bus.in_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got 0x%0h expected no output", bus.out_data);
        end else begin
          exp = sb.pop_front();
          if (bus.out_data !== exp) begin
            errors++;
            $display("FAIL out_data_order: got 0x%0h expected 0x%0h", bus.out_data, exp);
          end
        end
      end
    end
  end

  initial begin
    clr = 1'b1; en = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'(RVAL));
    chk("rst_ready_en0", 32'(bus.out_ready), 32'd0);
    en = 1'b1; #1;
    chk("rst_ready_en1", 32'(bus.out_ready), 32'd1);
    @(negedge clk);
    clr = 1'b0;

    // stream at full rate
    drive(1, 8'h11, 1, 1, 0, 1);
    chk("s1_valid", 32'(bus.out_valid), 32'd1);
    chk("s1_data",  32'(bus.out_data),  32'h11);
    drive(1, 8'h22, 1, 1, 0, 1);
    chk("s2_data",  32'(bus.out_data),  32'h22);
    chk("s2_ready", 32'(bus.out_ready), 32'd1);
    drive(1, 8'h33, 1, 1, 0, 1);
    chk("s3_data",  32'(bus.out_data),  32'h33);
    drive(0, 8'h00, 1, 1, 0, 0);
    chk("s_drain_valid", 32'(bus.out_valid), 32'd0);

    // backpressure into skid
    drive(1, 8'hA1, 0, 1, 0, 1);
    drive(1, 8'hA2, 0, 1, 0, 1);
    chk("full_ready", 32'(bus.out_ready), 32'd0);
    chk("full_data",  32'(bus.out_data),  32'hA1);

    // stall while full
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hEE, 1, 0, 0, 0);
      chk("stall_data",  32'(bus.out_data),  32'hA1);
      chk("stall_ready", 32'(bus.out_ready), 32'd0);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
    end
    drive(0, 8'h00, 1, 1, 0, 0);
    chk("unskid_ready", 32'(bus.out_ready), 32'd1);
    chk("unskid_data",  32'(bus.out_data),  32'hA2);
    drive(0, 8'h00, 1, 1, 0, 0);
    chk("unskid_empty", 32'(bus.out_valid), 32'd0);

    // flush while full with a coincident push
    drive(1, 8'hB1, 0, 1, 0, 1);
    drive(1, 8'hB2, 0, 1, 0, 1);
    chk("pre_flush_ready", 32'(bus.out_ready), 32'd0);
    sb.delete();
    drive(1, 8'hFF, 1, 1, 1, 0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_data",  32'(bus.out_data),  32'(RVAL));
    chk("flush_ready", 32'(bus.out_ready), 32'd1);
    drive(0, 8'h00, 1, 1, 0, 0);
    chk("post_flush_valid", 32'(bus.out_valid), 32'd0);

    // asynchronous clear between edges
    drive(1, 8'hC3, 0, 1, 0, 1);
    chk("one_data", 32'(bus.out_data), 32'hC3);
    bus.in_valid = 1'b0;
    #2 clr = 1'b1;
    sb.delete();
    #1;
    chk("aclr_valid", 32'(bus.out_valid), 32'd0);
    chk("aclr_data",  32'(bus.out_data),  32'(RVAL));
    chk("aclr_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // counters: one bubble edge, then 20 stalled edges
    drive(1, 8'hD4, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++) drive(0, 8'h00, 0, 1, 0, 0);
`ifdef STAGE_PERF_CNT_EN
    chk("stall_sat",  32'(stall_cnt),  32'd15);
    chk("bubble_one", 32'(bubble_cnt), 32'd1);
`else
    chk("stall_tied",  32'(stall_cnt),  32'd0);
    chk("bubble_tied", 32'(bubble_cnt), 32'd0);
`endif
    sb.delete();
    drive(0, 8'h00, 0, 1, 1, 0);
`ifdef STAGE_PERF_CNT_EN
    chk("stall_after_flush",  32'(stall_cnt),  32'd15);
    chk("bubble_after_flush", 32'(bubble_cnt), 32'd1);
`else
    chk("stall_after_flush",  32'(stall_cnt),  32'd0);
`endif
    clr = 1'b1; #1;
    chk("cnt_clr_stall",  32'(stall_cnt),  32'd0);
    chk("cnt_clr_bubble", 32'(bubble_cnt), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
